// File: rtl/instr_fetch_queue_if.sv
// Fetch-unit bundle: instruction-memory read port, redirect, and the
// two-slot presentation to the decoders.
//   master : the fetch queue itself
//   slave  : the environment (IM + decoders + branch resolution)
interface instr_fetch_queue_if #(
    parameter int AW = 16
);
    // instruction memory side
    logic [AW-1:0] im_addr;
    logic          im_re;
    logic [63:0]   im_rdata;

    // redirect from branch/jump resolution
    logic          flush;
    logic [AW-1:0] flush_pc;

    // decoder side
    logic [1:0]    deq_cnt;
    logic          out_valid0;
    logic [31:0]   out_instr0;
    logic [AW-1:0] out_pc0;
    logic          out_valid1;
    logic [31:0]   out_instr1;
    logic [AW-1:0] out_pc1;
    logic          halted;

    modport master (
        output im_addr, im_re,
        input  im_rdata,
        input  flush, flush_pc,
        input  deq_cnt,
        output out_valid0, out_instr0, out_pc0,
        output out_valid1, out_instr1, out_pc1,
        output halted
    );

    modport slave (
        input  im_addr, im_re,
        output im_rdata,
        output flush, flush_pc,
        output deq_cnt,
        input  out_valid0, out_instr0, out_pc0,
        input  out_valid1, out_instr1, out_pc1,
        input  halted
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch front end. Owns the fetch PC, issues aligned
// two-word reads to instruction memory (data returns one cycle later),
// buffers returned instructions in an in-order circular queue and shows
// the two oldest entries (registered) to the pair of decoders.
// A HLT opcode stops fetching until the next flush.
// Optional feature macro: IFQ_PERF_EN adds stall_cycles / flush_count.
module instr_fetch_queue #(
    parameter int            DEPTH    = 8,
    parameter int            AW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [4:0]    HLT_OP   = 5'b11111
) (
    input  logic                   clk,
    input  logic                   rst_n,
    instr_fetch_queue_if.master    bus
`ifdef IFQ_PERF_EN
    ,
    output logic [31:0]            stall_cycles,
    output logic [31:0]            flush_count
`endif
);

    localparam int PW = $clog2(DEPTH);   // pointer width
    localparam int CW = PW + 1;          // occupancy width (0..DEPTH)
    localparam int SW = CW + 1;          // headroom for the room check sum

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("instr_fetch_queue: DEPTH must be a power of 2 and at least 4");
    end

    // ------------------------------------------------------------------
    // Queue storage (not reset: contents are only meaningful below count)
    // ------------------------------------------------------------------
    logic [31:0]   instr_mem [DEPTH];
    logic [AW-1:0] pc_mem    [DEPTH];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [AW-1:0] pc_q,          pc_d;
    ptr_t          rd_ptr_q,      rd_ptr_d;
    ptr_t          wr_ptr_q,      wr_ptr_d;
    cnt_t          count_q,       count_d;
    logic          inflight_q,    inflight_d;
    logic [1:0]    inflight_n_q,  inflight_n_d;
    logic [AW-1:0] inflight_pc_q, inflight_pc_d;
    logic          halted_q,      halted_d;

    logic          out_valid0_q,  out_valid0_d;
    logic          out_valid1_q,  out_valid1_d;
    logic [31:0]   out_instr0_q,  out_instr0_d;
    logic [31:0]   out_instr1_q,  out_instr1_d;
    logic [AW-1:0] out_pc0_q,     out_pc0_d;
    logic [AW-1:0] out_pc1_q,     out_pc1_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [1:0]    pend_n;
    logic [SW-1:0] need;
    logic          room_ok;
    logic          im_re_c;

    logic          resp_ok;
    logic [31:0]   lo_word, hi_word;
    logic          lo_hlt, hi_hlt;
    logic          we0, we1;
    logic [31:0]   wd0, wd1;
    logic [AW-1:0] wp0, wp1;
    logic          halt_hit;
    cnt_t          enq_n;
    cnt_t          deq_n;

    // Request gating: a new pair may only be requested when the queue can
    // absorb it on top of whatever is already committed (stored entries
    // plus the response still due). Dequeues are not credited, which keeps
    // the check conservative and independent of the decoders.
    always_comb begin
        pend_n  = inflight_q ? inflight_n_q : 2'd0;
        need    = SW'(count_q) + SW'(pend_n) + SW'(2);
        room_ok = (need <= SW'(DEPTH));
        im_re_c = rst_n && !halted_q && !bus.flush && room_ok;
    end

    // Response decode: choose which words of the returned pair enter the
    // queue, and stop at the first HLT so nothing behind it is kept.
    always_comb begin
        lo_word  = bus.im_rdata[31:0];
        hi_word  = bus.im_rdata[63:32];
        lo_hlt   = (lo_word[31:27] == HLT_OP);
        hi_hlt   = (hi_word[31:27] == HLT_OP);
        // a response arriving after a halt belongs to a request that raced
        // the halt and is thrown away
        resp_ok  = inflight_q && !bus.flush && !halted_q;

        we0      = 1'b0;
        we1      = 1'b0;
        wd0      = lo_word;
        wp0      = inflight_pc_q;
        wd1      = hi_word;
        wp1      = inflight_pc_q + AW'(1);
        halt_hit = 1'b0;

        if (resp_ok) begin
            if (!inflight_pc_q[0]) begin
                // even start: both words, unless the first one halts
                we0 = 1'b1;
                if (lo_hlt) begin
                    halt_hit = 1'b1;
                end else begin
                    we1      = 1'b1;
                    halt_hit = hi_hlt;
                end
            end else begin
                // odd start (after a redirect): only the odd word is wanted
                we0      = 1'b1;
                wd0      = hi_word;
                halt_hit = hi_hlt;
            end
        end

        enq_n = cnt_t'(we0) + cnt_t'(we1);
    end

    // Dequeue amount: decoders may ask for more than is present; clamp.
    always_comb begin
        deq_n = (cnt_t'(bus.deq_cnt) > count_q) ? count_q : cnt_t'(bus.deq_cnt);
    end

    // Next-state for PC, pointers, occupancy and in-flight bookkeeping.
    // A flush overrides everything: queue empties, fetch restarts at the
    // redirect target on the following cycle.
    always_comb begin
        pc_d          = pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        inflight_d    = 1'b0;
        inflight_n_d  = inflight_n_q;
        inflight_pc_d = inflight_pc_q;
        halted_d      = halted_q;

        if (bus.flush) begin
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            inflight_d = 1'b0;
            halted_d   = 1'b0;
            pc_d       = bus.flush_pc;
        end else begin
            rd_ptr_d = rd_ptr_q + ptr_t'(deq_n);
            wr_ptr_d = wr_ptr_q + ptr_t'(enq_n);
            count_d  = count_q - deq_n + enq_n;
            halted_d = halted_q | halt_hit;
            if (im_re_c) begin
                inflight_d    = 1'b1;
                inflight_n_d  = pc_q[0] ? 2'd1 : 2'd2;
                inflight_pc_d = pc_q;
                pc_d          = {pc_q[AW-1:1] + (AW-1)'(1), 1'b0};
            end
        end
    end

    // Output slot reads: entry at rd_ptr_d (+1), forwarding anything being
    // written this cycle so the registered outputs see it one cycle later.
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        ptr_t          idx;
        logic [31:0]   instr;
        logic [AW-1:0] pc;

        // per-slot read with write-through of this cycle's enqueue
        always_comb begin
            idx   = rd_ptr_d + ptr_t'(gi);
            instr = instr_mem[idx];
            pc    = pc_mem[idx];
            if (we0 && idx == wr_ptr_q) begin
                instr = wd0;
                pc    = wp0;
            end
            if (we1 && idx == wr_ptr_q + ptr_t'(1)) begin
                instr = wd1;
                pc    = wp1;
            end
        end
    end

    // Registered presentation to the decoders.
    always_comb begin
        out_valid0_d = (count_d >= cnt_t'(1));
        out_valid1_d = (count_d >= cnt_t'(2));
        out_instr0_d = g_slot[0].instr;
        out_pc0_d    = g_slot[0].pc;
        out_instr1_d = g_slot[1].instr;
        out_pc1_d    = g_slot[1].pc;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_n_q  <= 2'd0;
            inflight_pc_q <= '0;
            halted_q      <= 1'b0;
            out_valid0_q  <= 1'b0;
            out_valid1_q  <= 1'b0;
            out_instr0_q  <= '0;
            out_instr1_q  <= '0;
            out_pc0_q     <= '0;
            out_pc1_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_n_q  <= inflight_n_d;
            inflight_pc_q <= inflight_pc_d;
            halted_q      <= halted_d;
            out_valid0_q  <= out_valid0_d;
            out_valid1_q  <= out_valid1_d;
            out_instr0_q  <= out_instr0_d;
            out_instr1_q  <= out_instr1_d;
            out_pc0_q     <= out_pc0_d;
            out_pc1_q     <= out_pc1_d;
        end
    end

    // Queue entry writes (up to two consecutive slots per cycle).
    always_ff @(posedge clk) begin
        if (we0) begin
            instr_mem[wr_ptr_q] <= wd0;
            pc_mem[wr_ptr_q]    <= wp0;
        end
        if (we1) begin
            instr_mem[wr_ptr_q + ptr_t'(1)] <= wd1;
            pc_mem[wr_ptr_q + ptr_t'(1)]    <= wp1;
        end
    end

    assign bus.im_addr    = {pc_q[AW-1:1], 1'b0};
    assign bus.im_re      = im_re_c;
    assign bus.out_valid0 = out_valid0_q;
    assign bus.out_valid1 = out_valid1_q;
    assign bus.out_instr0 = out_instr0_q;
    assign bus.out_instr1 = out_instr1_q;
    assign bus.out_pc0    = out_pc0_q;
    assign bus.out_pc1    = out_pc1_q;
    assign bus.halted     = halted_q;

`ifdef IFQ_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q,  flush_count_d;

    // Saturating counters: cycles fetch could have run but did not request,
    // and number of redirects.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!halted_q && !bus.flush && !im_re_c && stall_cycles_q != 32'hFFFF_FFFF) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (bus.flush && flush_count_q != 32'hFFFF_FFFF) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Testbench for instr_fetch_queue: directed timing scenarios followed by a
// randomized run. Expected program order is generated from the memory image
// whenever fetch is (re)started; a negedge monitor compares presented slots.
module tb_instr_fetch_queue;
    localparam int         AW  = 16;
    localparam logic [4:0] HLT = 5'b11111;
    localparam int         STREAM_LEN = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_queue_if #(.AW(AW)) bus ();

`ifdef IFQ_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    instr_fetch_queue #(
        .DEPTH(8), .AW(AW), .RESET_PC(16'h0000), .HLT_OP(HLT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef IFQ_PERF_EN
        , .stall_cycles(stall_cycles)
        , .flush_count(flush_count)
`endif
    );

    int total  = 0;
    int bad    = 0;
    int popped = 0;
    int nflush = 0;
    int hlt_pc = -1;   // address holding a HLT word, -1 for none

    // memory image: opcode field never equals HLT except at hlt_pc
    function automatic logic [31:0] imem(input logic [AW-1:0] a);
        if (hlt_pc >= 0 && a == AW'(hlt_pc)) return {HLT, 11'h5A5, a};
        return {2'b00, a[2:0], a[15:5] ^ 11'h123, a};
    endfunction

    // instruction memory: pair returned one cycle after the request
    always @(posedge clk) begin
        if (bus.im_re) bus.im_rdata <= {imem(bus.im_addr + 16'd1), imem(bus.im_addr)};
        else           bus.im_rdata <= {$urandom, $urandom};
    end

    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   instr;
    } exp_t;
    exp_t exp_q[$];

    // expected program order from start: sequential PCs up to and incl. HLT
    task automatic load_stream(input logic [AW-1:0] start);
        logic [AW-1:0] p;
        exp_t e;
        p = start;
        exp_q.delete();
        for (int i = 0; i < STREAM_LEN; i++) begin
            e.pc    = p;
            e.instr = imem(p);
            exp_q.push_back(e);
            if (e.instr[31:27] == HLT) break;
            p = p + 16'd1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // monitor: every presented slot must match the next expected entries
    always @(negedge clk) begin
        int nv;
        int take;
        logic [AW-1:0] got_pc;
        logic [31:0]   got_in;
        if (rst_n && !bus.flush) begin
            nv = bus.out_valid0 ? (bus.out_valid1 ? 2 : 1) : 0;
            if (bus.out_valid1 && !bus.out_valid0) begin
                total++; bad++;
                $display("FAIL valid_order: got valid1=1 valid0=0, required valid1 only with valid0");
            end
            if (bus.im_re) begin
                total++;
                if (bus.im_addr[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL im_addr_align: got %h, required even", bus.im_addr);
                end
            end
            take = (int'(bus.deq_cnt) < nv) ? int'(bus.deq_cnt) : nv;
            for (int k = 0; k < nv; k++) begin
                got_pc = (k == 0) ? bus.out_pc0 : bus.out_pc1;
                got_in = (k == 0) ? bus.out_instr0 : bus.out_instr1;
                total++;
                if (k >= exp_q.size()) begin
                    bad++;
                    $display("FAIL extra_slot%0d: got pc=%h instr=%h, required no valid entry", k, got_pc, got_in);
                end else if (got_pc !== exp_q[k].pc || got_in !== exp_q[k].instr) begin
                    bad++;
                    $display("FAIL slot%0d_data: got pc=%h instr=%h, required pc=%h instr=%h",
                             k, got_pc, got_in, exp_q[k].pc, exp_q[k].instr);
                end
            end
            for (int k = 0; k < take; k++) begin
                if (exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    popped++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // one flush cycle; returns at the drive point of the following cycle
    task automatic do_flush(input logic [AW-1:0] p, input int hlt);
        bus.flush    = 1'b1;
        bus.flush_pc = p;
        bus.deq_cnt  = 2'($urandom_range(0, 2));
        hlt_pc       = hlt;
        load_stream(p);
        nflush++;
        samp();
        chk("flush_im_re", bus.im_re, 0);
        step();
        bus.flush = 1'b0;
    endtask

    function automatic logic [1:0] rand_deq();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2) return 2'd0;
        if (r < 5) return 2'd1;
        return 2'd2;
    endfunction

    initial begin
        int pulses;
        bus.flush    = 1'b0;
        bus.flush_pc = '0;
        bus.deq_cnt  = 2'd2;

        // reset state
        repeat (3) step();
        samp();
        chk("rst_valid0", bus.out_valid0, 0);
        chk("rst_valid1", bus.out_valid1, 0);
        chk("rst_im_re",  bus.im_re, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_pc0",    bus.out_pc0, 0);

        // release, sequential fetch with deq_cnt=2
        step();
        rst_n = 1'b1;
        load_stream(16'h0000);
        samp();
        chk("c0_im_re", bus.im_re, 1);
        chk("c0_im_addr", bus.im_addr, 0);
        step(); samp();
        chk("c1_valid0", bus.out_valid0, 0);
        chk("c1_im_addr", bus.im_addr, 2);
        step(); samp();
        chk("c2_valid0", bus.out_valid0, 1);
        chk("c2_valid1", bus.out_valid1, 1);
        chk("c2_pc0", bus.out_pc0, 0);
        chk("c2_pc1", bus.out_pc1, 1);
        for (int i = 3; i < 7; i++) begin
            step(); samp();
            chk("steady_im_addr", bus.im_addr, 2 * i);
            chk("steady_valid1", bus.out_valid1, 1);
            chk("steady_pc0", bus.out_pc0, 2 * (i - 2));
        end

        // fill with no dequeue: exactly four pair requests, queue full
        step();
        do_flush(16'h0000, -1);
        bus.deq_cnt = 2'd0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            samp();
            if (bus.im_re) pulses++;
            if (i < 11) step();
        end
        chk("fill_requests", pulses, 4);
        chk("fill_im_re_low", bus.im_re, 0);
        chk("fill_pc0", bus.out_pc0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            bus.deq_cnt = 2'd2;
            samp();
            chk("drain_pc0", bus.out_pc0, 2 * i);
        end

        // flush to odd target while a response is in flight
        repeat (3) begin step(); samp(); end
        step();
        do_flush(16'd5, -1);
        bus.deq_cnt = 2'd2;
        samp();
        chk("f5_valid0_a", bus.out_valid0, 0);
        chk("f5_im_re", bus.im_re, 1);
        chk("f5_im_addr", bus.im_addr, 4);
        step(); samp();
        chk("f5_valid0_b", bus.out_valid0, 0);
        chk("f5_im_addr_next", bus.im_addr, 6);
        step(); samp();
        chk("f5_valid0_c", bus.out_valid0, 1);
        chk("f5_pc0", bus.out_pc0, 5);
        chk("f5_valid1_c", bus.out_valid1, 0);
        step(); samp();
        chk("clamp_valid1", bus.out_valid1, 1);
        chk("clamp_pc0", bus.out_pc0, 6);
        chk("clamp_pc1", bus.out_pc1, 7);

        // HLT in the even slot of the pair at 10
        step();
        do_flush(16'd8, 10);
        bus.deq_cnt = 2'd2;
        for (int i = 1; i <= 10; i++) begin
            samp();
            if (i >= 4) begin
                chk("hlt_halted", bus.halted, 1);
                chk("hlt_im_re", bus.im_re, 0);
            end
            if (i == 4) begin
                chk("hlt_pc0", bus.out_pc0, 10);
                chk("hlt_valid1", bus.out_valid1, 0);
            end
            if (i >= 5) chk("hlt_empty", bus.out_valid0, 0);
            if (i < 10) step();
        end
        step();
        do_flush(16'h0000, -1);
        samp();
        chk("unhalt_halted", bus.halted, 0);
        chk("unhalt_im_re", bus.im_re, 1);
        chk("unhalt_im_addr", bus.im_addr, 0);

        // asynchronous reset with five entries held
        step();
        do_flush(16'd1, -1);
        bus.deq_cnt = 2'd0;
        samp();
        repeat (4) begin step(); samp(); end
        chk("hold5_valid1", bus.out_valid1, 1);
        chk("hold5_pc0", bus.out_pc0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid0", bus.out_valid0, 0);
        chk("arst_valid1", bus.out_valid1, 0);
        chk("arst_pc0", bus.out_pc0, 0);
        chk("arst_instr1", bus.out_instr1, 0);
        chk("arst_im_re", bus.im_re, 0);
        step();
        step();
        rst_n = 1'b1;
        hlt_pc = -1;
        load_stream(16'h0000);
        bus.deq_cnt = 2'd2;
        samp();
        chk("rerst_im_re", bus.im_re, 1);
        chk("rerst_im_addr", bus.im_addr, 0);

        // randomized traffic with occasional redirects and halts
        popped = 0;
        for (int c = 0; c < 800; c++) begin
            step();
            if ($urandom_range(0, 39) == 0) begin
                logic [AW-1:0] tgt;
                int h;
                if ($urandom_range(0, 3) == 0) tgt = 16'hFFF8 + 16'($urandom_range(0, 7));
                else tgt = 16'($urandom_range(0, 65535));
                h = ($urandom_range(0, 2) == 0) ? int'(16'(tgt + 16'($urandom_range(0, 12)))) : -1;
                do_flush(tgt, h);
            end
            bus.deq_cnt = rand_deq();
            samp();
        end
        total++;
        if (popped < 100) begin
            bad++;
            $display("FAIL progress: got %0d dequeued, required at least 100", popped);
        end

`ifdef IFQ_PERF_EN
        chk("perf_flush_count", flush_count, 32'(nflush));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
